// File: rtl/studio_keypad_pkg.sv
// Shared types, limits and the power-on scancode table for the keypad front end.
package studio_keypad_pkg;

  localparam int unsigned MAX_PADS = 4;
  localparam int unsigned MAX_KEYS = 16;

  // {extended, scancode}
  typedef logic [8:0] scan_code_t;

  // Table filler that no real event can select (the lookup also skips it explicitly)
  localparam scan_code_t SCAN_NONE = 9'h1FF;

  // Pad 0: digit row 0..9
  localparam logic [7:0] PAD0_CODES [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
  };

  // Pad 1: P Q W E R T Y U I O
  localparam logic [7:0] PAD1_CODES [10] = '{
    8'h4D, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44
  };

  // Power-on mapping for one (pad, key) entry
  function automatic scan_code_t default_code(input logic [1:0] pad, input logic [3:0] key);
    scan_code_t code;
    code = SCAN_NONE;
    if (key < 4'd10) begin
      if (pad == 2'd0) code = {1'b0, PAD0_CODES[key]};
      if (pad == 2'd1) code = {1'b0, PAD1_CODES[key]};
    end
    return code;
  endfunction

endpackage

// File: rtl/studio_key_cell.sv
// One key: a down bit plus a tick-driven hold counter so short taps stay visible.
module studio_key_cell #(
  parameter int unsigned HOLD_TICKS = 3
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic press,
  input  logic rel,
  input  logic tick,
  input  logic clear,
  output logic visible
);

  localparam int unsigned HoldW = (HOLD_TICKS == 0) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_TICKS);

  logic             down_q, down_d;
  logic [HoldW-1:0] hold_q, hold_d;

  // Next state: clear beats everything, a press load beats a tick decrement
  always_comb begin
    down_d = down_q;
    hold_d = hold_q;
    if (clear) begin
      down_d = 1'b0;
      hold_d = '0;
    end else begin
      if (press) begin
        down_d = 1'b1;
      end else if (rel) begin
        down_d = 1'b0;
      end
      if (press) begin
        hold_d = HoldLoad;
      end else if (tick && (hold_q != '0)) begin
        hold_d = hold_q - HoldW'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      down_q <= 1'b0;
      hold_q <= '0;
    end else begin
      down_q <= down_d;
      hold_q <= hold_d;
    end
  end

  assign visible = down_q | (hold_q != '0);

endmodule

// File: rtl/studio_keypad_scan.sv
// PS/2 key events -> remappable table -> per-pad key states, key-select latch and EF flags.
module studio_keypad_scan
  import studio_keypad_pkg::*;
#(
  parameter int unsigned NUM_PADS     = 2,
  parameter int unsigned KEYS_PER_PAD = 10,
  parameter int unsigned HOLD_TICKS   = 3,
  parameter int unsigned PORT_SEL     = 1,
  parameter int unsigned EF_INVERT    = 0
) (
  input  logic                             clk_sys,
  input  logic                             reset_n,
  input  logic [10:0]                      ps2_key,
  input  logic [2:0]                       io_n,
  input  logic                             io_out,
  input  logic [7:0]                       cpu_dout,
  input  logic                             tick,
  input  logic                             clear_all,
  input  logic                             map_we,
  input  logic [5:0]                       map_idx,
  input  logic [8:0]                       map_code,
  output logic [3:0]                       keylatch,
  output logic [NUM_PADS*KEYS_PER_PAD-1:0] key_state,
  output logic [NUM_PADS-1:0]              ef_keys
);

  localparam logic EfInv = (EF_INVERT != 0);

  logic       toggle_q;
  logic       primed_q;
  logic       key_evt;
  scan_code_t evt_code;

  scan_code_t map_q [NUM_PADS][KEYS_PER_PAD];

  logic [NUM_PADS-1:0][KEYS_PER_PAD-1:0] hit;
  logic [NUM_PADS-1:0][KEYS_PER_PAD-1:0] vis;
  logic [NUM_PADS-1:0]                   ef_d;

  // The first clock after reset only samples the toggle, so a stale 1 is not a press
  assign key_evt  = primed_q && (ps2_key[10] != toggle_q);
  assign evt_code = {ps2_key[8], ps2_key[7:0]};

  // Toggle edge detector and priming flag
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      toggle_q <= ps2_key[10];
      primed_q <= 1'b1;
    end
  end

  // Scancode table; out-of-range indices simply match no entry
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        for (int k = 0; k < KEYS_PER_PAD; k++) begin
          map_q[p][k] <= default_code(2'(p), 4'(k));
        end
      end
    end else begin
      for (int p = 0; p < NUM_PADS; p++) begin
        for (int k = 0; k < KEYS_PER_PAD; k++) begin
          if (map_we && (map_idx == 6'(p * 16 + k))) map_q[p][k] <= map_code;
        end
      end
    end
  end

  // Parallel lookup against the pre-write table contents
  always_comb begin
    hit = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      for (int k = 0; k < KEYS_PER_PAD; k++) begin
        hit[p][k] = key_evt && (map_q[p][k] != SCAN_NONE) && (map_q[p][k] == evt_code);
      end
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    for (genvar k = 0; k < KEYS_PER_PAD; k++) begin : g_key
      studio_key_cell #(
        .HOLD_TICKS(HOLD_TICKS)
      ) u_cell (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .press  (hit[p][k] && ps2_key[9]),
        .rel    (hit[p][k] && !ps2_key[9]),
        .tick   (tick),
        .clear  (clear_all),
        .visible(vis[p][k])
      );
    end
  end

  assign key_state = vis;

  // Key-select latch loaded from the CPU OUT cycle on the chosen port
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      keylatch <= 4'd0;
    end else if (io_out && (io_n == 3'(PORT_SEL))) begin
      keylatch <= cpu_dout[3:0];
    end
  end

  // Selected key per pad; a latch value past the last key reads as released
  always_comb begin
    ef_d = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      for (int k = 0; k < KEYS_PER_PAD; k++) begin
        if (keylatch == 4'(k)) ef_d[p] = vis[p][k];
      end
    end
  end

  // Registered EF flags
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ef_keys <= {NUM_PADS{EfInv}};
    end else begin
      ef_keys <= ef_d ^ {NUM_PADS{EfInv}};
    end
  end

endmodule
